// File: rtl/motion_axis_detect.sv
// motion_axis_detect
//   Multi-axis movement detector for the accelerometer path. Each signed axis
//   sample is converted to a magnitude and qualified against THRESH through a
//   per-axis IDLE/PEND/HELD debounce FSM. The block reports the held direction
//   of every axis, a global movement flag, the dominant held axis, a pulse when
//   movement toggles, and a rescan pulse that requests the next sensor read.
//
//   Build option: define MOTION_HYST_EN so that a held axis releases at
//   THRESH-HYST. Without it, the assert and release thresholds are both THRESH.
//
// Ports
//   clk           system clock
//   reset         synchronous active-high reset
//   sample_tick   sampling strobe from the timebase
//   completed     the sensor reader has a fresh sample set
//   samples       packed signed samples; axis i at [i*DATA_W +: DATA_W]
//   rescan        one-cycle pulse per accepted sample set
//   axis_dir      axis i: bit 2i = held positive, bit 2i+1 = held negative
//   movement      OR of all held axes
//   dom_axis      held axis with the largest magnitude (0 when no movement)
//   move_changed  one-cycle pulse when movement toggles
module motion_axis_detect #(
  parameter int DATA_W   = 8,
  parameter int NUM_AXES = 3,
  parameter int THRESH   = 80,
  parameter int HYST     = 16,
  parameter int DEBOUNCE = 2,
  localparam int DOM_W   = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_tick,
  input  logic                         completed,
  input  logic [NUM_AXES*DATA_W-1:0]   samples,
  output logic                         rescan,
  output logic [2*NUM_AXES-1:0]        axis_dir,
  output logic                         movement,
  output logic [DOM_W-1:0]             dom_axis,
  output logic                         move_changed
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    HELD = 2'd2
  } axis_state_t;

`ifdef MOTION_HYST_EN
  localparam int RELEASE = THRESH - HYST;
`else
  localparam int RELEASE = THRESH;
`endif

  logic accept;
  assign accept = sample_tick && completed;

  axis_state_t         state_q [NUM_AXES];
  axis_state_t         state_d [NUM_AXES];
  logic [3:0]          cnt_q   [NUM_AXES];
  logic [3:0]          cnt_d   [NUM_AXES];
  logic                sign_q  [NUM_AXES];
  logic                sign_d  [NUM_AXES];
  logic [DATA_W-1:0]   mag     [NUM_AXES];

  logic [2*NUM_AXES-1:0] dir_d;
  logic                  movement_d;
  logic [DOM_W-1:0]      dom_d;

  // Per-axis magnitude and next-state logic.
  always_comb begin
    for (int i = 0; i < NUM_AXES; i++) begin
      logic [DATA_W-1:0] smp;
      logic              s_neg;
      logic              over;
      logic              above_rel;
      logic [3:0]        cnt_inc;
      // NOTE: every combinational output gets a default before any branch so
      // no path leaves it unassigned and no latch is inferred.
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      sign_d[i]  = sign_q[i];

      smp   = samples[i*DATA_W +: DATA_W];
      s_neg = smp[DATA_W-1];
      // Negation in DATA_W bits maps the most negative value onto 2^(DATA_W-1).
      mag[i]    = s_neg ? (DATA_W'(0) - smp) : smp;
      over      = 32'(mag[i]) > 32'(THRESH);
      above_rel = 32'(mag[i]) > 32'(RELEASE);
      cnt_inc   = (cnt_q[i] == 4'd15) ? 4'd15 : cnt_q[i] + 4'd1;

      if (accept) begin
        unique case (state_q[i])
          IDLE: begin
            if (over) begin
              sign_d[i]  = s_neg;
              cnt_d[i]   = 4'd1;
              state_d[i] = (DEBOUNCE == 1) ? HELD : PEND;
            end
          end
          PEND: begin
            if (over && (s_neg == sign_q[i])) begin
              cnt_d[i] = cnt_inc;
              if (32'(cnt_inc) >= 32'(DEBOUNCE)) state_d[i] = HELD;
            end else if (over) begin
              cnt_d[i]  = 4'd1;
              sign_d[i] = s_neg;
            end else begin
              state_d[i] = IDLE;
              cnt_d[i]   = 4'd0;
            end
          end
          HELD: begin
            if (above_rel && (s_neg == sign_q[i])) begin
              state_d[i] = HELD;
            end else if (over && (s_neg != sign_q[i])) begin
              state_d[i] = PEND;
              cnt_d[i]   = 4'd1;
              sign_d[i]  = s_neg;
            end else begin
              state_d[i] = IDLE;
              cnt_d[i]   = 4'd0;
            end
          end
          default: begin
            state_d[i] = IDLE;
            cnt_d[i]   = 4'd0;
          end
        endcase
      end
    end
  end

  // Output values derived from the next state, registered on accept.
  always_comb begin
    logic              found;
    logic [DATA_W-1:0] best_mag;
    dir_d      = '0;
    movement_d = 1'b0;
    dom_d      = '0;
    found      = 1'b0;
    best_mag   = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      if (state_d[i] == HELD) begin
        dir_d[2*i]   = !sign_d[i];
        dir_d[2*i+1] = sign_d[i];
        movement_d   = 1'b1;
        // Strict compare keeps the lowest index on ties.
        if (!found || (mag[i] > best_mag)) begin
          found    = 1'b1;
          best_mag = mag[i];
          dom_d    = DOM_W'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      // NOTE: the per-axis state arrays are flop-based and must start IDLE
      // with a zero count, so they are reset like any other register.
      for (int i = 0; i < NUM_AXES; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= 4'd0;
        sign_q[i]  <= 1'b0;
      end
      rescan       <= 1'b0;
      axis_dir     <= '0;
      movement     <= 1'b0;
      dom_axis     <= '0;
      move_changed <= 1'b0;
    end else begin
      rescan       <= accept;
      move_changed <= 1'b0;
      if (accept) begin
        for (int i = 0; i < NUM_AXES; i++) begin
          state_q[i] <= state_d[i];
          cnt_q[i]   <= cnt_d[i];
          sign_q[i]  <= sign_d[i];
        end
        axis_dir     <= dir_d;
        movement     <= movement_d;
        dom_axis     <= dom_d;
        move_changed <= (movement_d != movement);
      end
    end
  end

endmodule

// File: tb/tb_motion_axis_detect.sv
// Directed testbench for motion_axis_detect with default parameters
// (DATA_W=8, NUM_AXES=3, THRESH=80, HYST=16, DEBOUNCE=2). Expected values are
// hand-computed; hysteresis expectations follow the MOTION_HYST_EN setting.
module tb_motion_axis_detect;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        completed;
  logic [23:0] samples;
  logic        rescan;
  logic [5:0]  axis_dir;
  logic        movement;
  logic [1:0]  dom_axis;
  logic        move_changed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motion_axis_detect dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .completed    (completed),
    .samples      (samples),
    .rescan       (rescan),
    .axis_dir     (axis_dir),
    .movement     (movement),
    .dom_axis     (dom_axis),
    .move_changed (move_changed)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One accept cycle: drive on the falling edge, sample 1 time unit after the
  // capturing rising edge, then drop sample_tick.
  task automatic do_accept(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2);
    @(negedge clk);
    samples     = {s2, s1, s0};
    sample_tick = 1'b1;
    completed   = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    completed   = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    completed   = 1'b0;
    samples     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rescan",   32'(rescan),       32'd0);
    check("rst_axis_dir", 32'(axis_dir),     32'd0);
    check("rst_movement", 32'(movement),     32'd0);
    check("rst_dom",      32'(dom_axis),     32'd0);
    check("rst_mchg",     32'(move_changed), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Axis0 = +90 twice: pending after the first, held after the second.
    do_accept(8'd90, 8'd0, 8'd0);
    check("a1_rescan",   32'(rescan),   32'd1);
    check("a1_axis_dir", 32'(axis_dir), 32'd0);
    check("a1_movement", 32'(movement), 32'd0);
    idle_cycle();
    check("a1_rescan_drop", 32'(rescan), 32'd0);
    do_accept(8'd90, 8'd0, 8'd0);
    check("a2_axis_dir", 32'(axis_dir),     32'h01);
    check("a2_movement", 32'(movement),     32'd1);
    check("a2_mchg",     32'(move_changed), 32'd1);
    check("a2_dom",      32'(dom_axis),     32'd0);
    idle_cycle();
    check("a2_mchg_drop", 32'(move_changed), 32'd0);

    // Release behaviour: +70 then +64.
    do_accept(8'd70, 8'd0, 8'd0);
`ifdef MOTION_HYST_EN
    check("h70_axis_dir", 32'(axis_dir),     32'h01);
    check("h70_mchg",     32'(move_changed), 32'd0);
`else
    check("h70_axis_dir", 32'(axis_dir),     32'h00);
    check("h70_mchg",     32'(move_changed), 32'd1);
`endif
    do_accept(8'd64, 8'd0, 8'd0);
    check("h64_axis_dir", 32'(axis_dir), 32'h00);
    check("h64_movement", 32'(movement), 32'd0);
`ifdef MOTION_HYST_EN
    check("h64_mchg", 32'(move_changed), 32'd1);
`else
    check("h64_mchg", 32'(move_changed), 32'd0);
`endif

    // Axis1 = -128 and axis2 = +100 together; 128 beats 100 for dominance.
    do_accept(8'd0, 8'h80, 8'd100);
    check("neg1_axis_dir", 32'(axis_dir), 32'h00);
    do_accept(8'd0, 8'h80, 8'd100);
    check("neg2_axis_dir", 32'(axis_dir), 32'h18);
    check("neg2_movement", 32'(movement), 32'd1);
    check("neg2_dom",      32'(dom_axis), 32'd1);
    do_accept(8'd0, 8'd0, 8'd0);
    check("zero_axis_dir", 32'(axis_dir),     32'h00);
    check("zero_mchg",     32'(move_changed), 32'd1);
    check("zero_dom",      32'(dom_axis),     32'd0);

    // Sign flip while pending: +90, -90, -90 (-90 = 0xA6).
    do_accept(8'd90, 8'd0, 8'd0);
    check("flip1_axis_dir", 32'(axis_dir), 32'h00);
    do_accept(8'hA6, 8'd0, 8'd0);
    check("flip2_axis_dir", 32'(axis_dir), 32'h00);
    do_accept(8'hA6, 8'd0, 8'd0);
    check("flip3_axis_dir", 32'(axis_dir), 32'h02);
    check("flip3_movement", 32'(movement), 32'd1);

    // completed without sample_tick: nothing may change.
    @(negedge clk);
    completed = 1'b1;
    samples   = {8'd0, 8'h80, 8'd5};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("noacc_rescan",   32'(rescan),       32'd0);
      check("noacc_axis_dir", 32'(axis_dir),     32'h02);
      check("noacc_mchg",     32'(move_changed), 32'd0);
    end
    completed = 1'b0;

    // Reset coincident with an accept wins.
    @(negedge clk);
    reset       = 1'b1;
    sample_tick = 1'b1;
    completed   = 1'b1;
    samples     = {8'd0, 8'h80, 8'hA6};
    @(posedge clk);
    #1;
    check("rstacc_rescan",   32'(rescan),       32'd0);
    check("rstacc_axis_dir", 32'(axis_dir),     32'd0);
    check("rstacc_movement", 32'(movement),     32'd0);
    check("rstacc_dom",      32'(dom_axis),     32'd0);
    check("rstacc_mchg",     32'(move_changed), 32'd0);
    sample_tick = 1'b0;
    completed   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    // Count restarted from zero: one accept is not enough to hold.
    do_accept(8'd0, 8'h80, 8'd0);
    check("post_rst_axis_dir", 32'(axis_dir), 32'h00);

    // Equal magnitudes on axes 0 and 2: tie goes to the lowest index.
    do_accept(8'd100, 8'd0, 8'd100);
    do_accept(8'd100, 8'd0, 8'd100);
    check("tie_axis_dir", 32'(axis_dir), 32'h11);
    check("tie_dom",      32'(dom_axis), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
